shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Multi-bit logical right-shift engine built around a single-bit right-shift stage. It accepts an operand and a shift amount over a valid/ready handshake, then applies the one-bit stage once per clock for the requested number of cycles. The result is presented on a valid/ready output port. It lets the datapath perform variable shifts while keeping only one shared 1-bit shifter instance.

Parameters:
WIDTH, 8, operand and result width in bits.
AMT_W, 3, shift-amount width in bits; the maximum shift is 2^AMT_W-1.

Ports:
clk  in  1  single clock for the whole block; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous abort; drops the operation in flight.
in_valid  in  1  requester presents an operand.
in_ready  out  1  block can accept an operand.
in_data  in  WIDTH  operand.
in_amt  in  AMT_W  number of bit positions to shift right.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  WIDTH  result (working register).
busy  out  1  high in SHIFT or HOLD.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, data_r=0, cnt_r=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- FSM states: IDLE, SHIFT, HOLD.
- Outputs decoded from state only:
  - in_ready = (state==IDLE).
  - out_valid = (state==HOLD).
  - busy = (state!=IDLE).
  - out_data = data_r at all times.
- IDLE:
  - On in_valid&in_ready, load data_r<=in_data and cnt_r<=in_amt.
  - Next state is HOLD if in_amt==0, else SHIFT.
- SHIFT (each cycle):
  - data_r <= data_r>>1, taken from the 1-bit stage output; zero fill into the MSB.
  - cnt_r <= cnt_r-1.
  - When cnt_r==1, next state is HOLD.
- HOLD:
  - data_r is frozen.
  - On out_valid&out_ready, go to IDLE.
  - No same-cycle accept: in_ready is low in HOLD.
- Latency and throughput:
  - Accept in cycle T gives out_valid high from cycle T+in_amt+1.
  - Minimum per-op occupancy is in_amt+2 cycles when out_ready is held high.
- Width rules:
  - The result is in_data >> in_amt (logical), truncated to WIDTH.
  - cnt_r is AMT_W bits and never underflows, because SHIFT is entered only with a nonzero count.
- Backpressure: out_valid and out_data stay stable in HOLD until accepted.
- flush:
  - Highest synchronous priority. In any state, next state is IDLE and cnt_r<=0.
  - data_r is left unchanged.
  - No out_valid is produced for the dropped operation.
  - An in_valid in the same cycle as flush is not accepted, even in IDLE.
- Reset mid-operation: all state clears immediately, independent of clk, and the operation is lost.
- in_data and in_amt are sampled only on the accept edge; later changes are ignored.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, SHIFT, HOLD);
  - the default WIDTH and AMT_W localparams.
- One sub-module, shr1_stage:
  - Combinational WIDTH-bit logical right shift by one.
  - Instantiated once; its input is data_r and its output feeds data_r in SHIFT.

Test Plan:
1. rst high then released -> in_ready=1, out_valid=0, out_data=0x00, busy=0; asserting rst mid-SHIFT returns these values with no clock edge.
2. Accept in_data=0xB4, in_amt=3 at T with out_ready=1 -> out_valid at T+4, out_data=0x16; in_ready high again at T+5.
3. in_data=0xA5, in_amt=0 -> out_valid at T+1, out_data=0xA5; in_data=0xFF, in_amt=7 -> out_valid at T+8, out_data=0x01.
4. Backpressure: result 0x16 pending, out_ready low for 5 cycles -> out_valid held, out_data=0x16 stable, in_ready=0; out_ready high -> IDLE next cycle.
5. flush on the second SHIFT cycle of an amt=5 op -> IDLE next cycle, out_valid never asserted; new op 0x80, amt=2 -> out_data=0x20.
6. Back-to-back ops with in_valid held high and random in_amt (200 ops) -> each out_data equals in_data>>in_amt; output order matches input order.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared types and default sizing for the shift sequencer.
package shift_sequencer_pkg;

  // Default operand width and shift-amount width.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_if.sv
// Handshake bundle of the shift sequencer: operand input, result output,
// abort request and activity indication.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  // Requester / consumer side.
  modport master (
    output flush, in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Sequencer side.
  modport slave (
    input  flush, in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface : shift_sequencer_if

// File: rtl/shift_sequencer_shr1_stage.sv
// Single shared one-bit logical right-shift stage (zero fill into the MSB).
module shr1_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {1'b0, din[WIDTH-1:1]};

endmodule : shr1_stage

// File: rtl/shift_sequencer.sv
// Variable logical right shifter that reuses one 1-bit stage, applying it
// once per clock for the requested number of positions.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input logic            clk,
  input logic            rst,
  shift_sequencer_if.slave bus
);

  state_t           state_r;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt;
  logic [AMT_W-1:0] cnt_r;
  logic [AMT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] shr_out;

  // The only shifter in the block; it always looks at the working register.
  shr1_stage #(.WIDTH(WIDTH)) u_shr1 (
    .din  (data_r),
    .dout (shr_out)
  );

  // State, working data and remaining-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      data_r  <= data_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next-state and datapath selection; flush overrides everything else and
  // leaves the working data untouched.
  always_comb begin
    state_nxt = state_r;
    data_nxt  = data_r;
    cnt_nxt   = cnt_r;
    if (bus.flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            data_nxt = bus.in_data;
            cnt_nxt  = bus.in_amt;
            if (bus.in_amt == {AMT_W{1'b0}}) begin
              state_nxt = HOLD;
            end else begin
              state_nxt = SHIFT;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        SHIFT: begin
          // Count is nonzero on entry, so the decrement cannot wrap.
          data_nxt = shr_out;
          cnt_nxt  = cnt_r - AMT_W'(1);
          if (cnt_r == AMT_W'(1)) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = SHIFT;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only; the result is the
  // working register itself, so both are glitch-free register outputs.
  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == HOLD);
  assign bus.busy      = (state_r != IDLE);
  assign bus.out_data  = data_r;

endmodule : shift_sequencer
